// File: rtl/bp_stats_pkg.sv
// Shared types and helpers for the branch statistics monitor.
// Also holds the default window length used by host-side hit-rate displays.
package bp_stats_pkg;

    localparam int unsigned DEFAULT_WINDOW = 100000;

    typedef enum logic {
        EMPTY,
        FULL
    } snap_state_e;

    // Counters narrower than 64 bits pass their own width to get the right ceiling.
    function automatic logic [63:0] sat_inc(
        input logic [63:0] val,
        input logic        inc,
        input int unsigned width
    );
        logic [63:0] max_v;
        max_v = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        if (inc && (val < max_v)) begin
            return val + 64'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/branch_stats_monitor_sat_counter.sv
// Saturating event counter with synchronous clear.
// Adds 0 or 1 per enabled cycle and sticks at its all-ones value.
module sat_counter
    import bp_stats_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = CNT_W'(sat_inc(64'(cnt_q), en_i & inc_i, CNT_W));
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_stats_monitor.sv
// Resolved-branch statistics: global and per-provider counters, fixed-size
// measurement windows and a snapshot handed off through valid/ack.
module branch_stats_monitor
    import bp_stats_pkg::*;
#(
    parameter int          CNT_W  = 32,
    parameter int unsigned WINDOW = DEFAULT_WINDOW,
    parameter int          NUM_CH = 4,
    parameter int          CH_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             br_valid,
    input  logic             br_correct,
    input  logic [CH_W-1:0]  br_ch,
    input  logic             clear,
    input  logic             freeze,
    output logic [CNT_W-1:0] total_branches,
    output logic [CNT_W-1:0] correct_predicted,
    output logic             win_valid,
    output logic [CNT_W-1:0] win_correct,
    output logic [CNT_W-1:0] win_index,
    input  logic             win_ack,
    output logic             win_overrun,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [CNT_W-1:0] rd_total,
    output logic [CNT_W-1:0] rd_correct
);

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic             ev;
    logic             close;
    logic [CNT_W-1:0] ch_tot [NUM_CH];
    logic [CNT_W-1:0] ch_cor [NUM_CH];

    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] wcor_q, wcor_d;
    logic [CNT_W-1:0] widx_q, widx_d;
    logic [CNT_W-1:0] rdt_q, rdt_d;
    logic [CNT_W-1:0] rdc_q, rdc_d;
    logic             ovr_q, ovr_d;
    snap_state_e      st_q, st_d;

    assign ev    = br_valid & ~freeze & ~clear;
    assign close = ev & (pos_q == LAST_POS);

    sat_counter #(.CNT_W(CNT_W)) u_tot (
        .clk(clk), .reset(reset), .clr_i(clear),
        .en_i(ev), .inc_i(1'b1), .cnt_o(total_branches)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cor (
        .clk(clk), .reset(reset), .clr_i(clear),
        .en_i(ev), .inc_i(br_correct), .cnt_o(correct_predicted)
    );

    // Out-of-range channel indices match no slot and are simply dropped.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic hit;
        assign hit = ev & (br_ch == CH_W'(gi));

        sat_counter #(.CNT_W(CNT_W)) u_ch_tot (
            .clk(clk), .reset(reset), .clr_i(clear),
            .en_i(hit), .inc_i(1'b1), .cnt_o(ch_tot[gi])
        );

        sat_counter #(.CNT_W(CNT_W)) u_ch_cor (
            .clk(clk), .reset(reset), .clr_i(clear),
            .en_i(hit), .inc_i(br_correct), .cnt_o(ch_cor[gi])
        );
    end

    always_comb begin
        rdt_d = '0;
        rdc_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rdt_d = ch_tot[i];
                rdc_d = ch_cor[i];
            end
        end
    end

    always_comb begin
        pos_d  = pos_q;
        acc_d  = acc_q;
        wcor_d = wcor_q;
        widx_d = widx_q;
        ovr_d  = ovr_q;
        st_d   = st_q;
        if (clear) begin
            pos_d  = '0;
            acc_d  = '0;
            wcor_d = '0;
            widx_d = '0;
            ovr_d  = 1'b0;
            st_d   = EMPTY;
        end else begin
            if (close) begin
                pos_d  = '0;
                acc_d  = '0;
                wcor_d = acc_q + CNT_W'(br_correct);
                widx_d = widx_q + ONE;
            end else if (ev) begin
                pos_d = pos_q + ONE;
                acc_d = acc_q + CNT_W'(br_correct);
            end
            unique case (st_q)
                EMPTY: begin
                    if (close) st_d = FULL;
                end
                FULL: begin
                    if (close) begin
                        if (!win_ack) ovr_d = 1'b1;
                    end else if (win_ack) begin
                        st_d = EMPTY;
                    end
                end
                default: st_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q  <= '0;
            acc_q  <= '0;
            wcor_q <= '0;
            widx_q <= '0;
            rdt_q  <= '0;
            rdc_q  <= '0;
            ovr_q  <= 1'b0;
            st_q   <= EMPTY;
        end else begin
            pos_q  <= pos_d;
            acc_q  <= acc_d;
            wcor_q <= wcor_d;
            widx_q <= widx_d;
            rdt_q  <= rdt_d;
            rdc_q  <= rdc_d;
            ovr_q  <= ovr_d;
            st_q   <= st_d;
        end
    end

    assign win_valid   = (st_q == FULL);
    assign win_correct = wcor_q;
    assign win_index   = widx_q;
    assign win_overrun = ovr_q;
    assign rd_total    = rdt_q;
    assign rd_correct  = rdc_q;

endmodule

// File: tb/tb_branch_stats_monitor.sv
// Two monitor configurations (wide 4-channel, narrow 3-channel) share one
// stimulus stream and are compared against a per-configuration count model.
module tb_branch_stats_monitor;

    localparam int WIN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       br_valid, br_correct, clear, freeze, win_ack;
    logic [1:0] br_ch, rd_ch;

    logic [31:0] a_tot, a_cor, a_wcor, a_widx, a_rdt, a_rdc;
    logic        a_wv, a_ovr;
    logic [3:0]  b_tot, b_cor, b_wcor, b_widx, b_rdt, b_rdc;
    logic        b_wv, b_ovr;

    int n_checks = 0;
    int n_err    = 0;

    int cw[2]  = '{32, 4};
    int nch[2] = '{4, 3};

    longint m_tot[2], m_cor[2], m_acc[2], m_cnt[2];
    longint m_wcor[2], m_widx[2], m_rdt[2], m_rdc[2];
    longint m_ct[2][4], m_cc[2][4];
    bit     m_pend[2], m_ovr[2];

    always #5 clk = ~clk;

    branch_stats_monitor #(.CNT_W(32), .WINDOW(WIN), .NUM_CH(4), .CH_W(2)) dut_a (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_correct(br_correct),
        .br_ch(br_ch), .clear(clear), .freeze(freeze),
        .total_branches(a_tot), .correct_predicted(a_cor),
        .win_valid(a_wv), .win_correct(a_wcor), .win_index(a_widx),
        .win_ack(win_ack), .win_overrun(a_ovr), .rd_ch(rd_ch),
        .rd_total(a_rdt), .rd_correct(a_rdc)
    );

    branch_stats_monitor #(.CNT_W(4), .WINDOW(WIN), .NUM_CH(3), .CH_W(2)) dut_b (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_correct(br_correct),
        .br_ch(br_ch), .clear(clear), .freeze(freeze),
        .total_branches(b_tot), .correct_predicted(b_cor),
        .win_valid(b_wv), .win_correct(b_wcor), .win_index(b_widx),
        .win_ack(win_ack), .win_overrun(b_ovr), .rd_ch(rd_ch),
        .rd_total(b_rdt), .rd_correct(b_rdc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_tot[k] = 0; m_cor[k] = 0; m_acc[k] = 0; m_cnt[k] = 0;
            m_wcor[k] = 0; m_widx[k] = 0; m_rdt[k] = 0; m_rdc[k] = 0;
            m_pend[k] = 0; m_ovr[k] = 0;
            for (int c = 0; c < 4; c++) begin
                m_ct[k][c] = 0;
                m_cc[k][c] = 0;
            end
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            longint mx = (longint'(1) << cw[k]) - 1;
            int rc = int'(rd_ch);
            int bc = int'(br_ch);
            m_rdt[k] = (rc < nch[k]) ? m_ct[k][rc] : 0;
            m_rdc[k] = (rc < nch[k]) ? m_cc[k][rc] : 0;
            if (clear) begin
                m_tot[k] = 0; m_cor[k] = 0; m_acc[k] = 0; m_cnt[k] = 0;
                m_wcor[k] = 0; m_widx[k] = 0; m_pend[k] = 0; m_ovr[k] = 0;
                for (int c = 0; c < 4; c++) begin
                    m_ct[k][c] = 0;
                    m_cc[k][c] = 0;
                end
            end else if (br_valid && !freeze) begin
                if (m_tot[k] < mx) m_tot[k]++;
                if (br_correct && m_cor[k] < mx) m_cor[k]++;
                if (bc < nch[k]) begin
                    if (m_ct[k][bc] < mx) m_ct[k][bc]++;
                    if (br_correct && m_cc[k][bc] < mx) m_cc[k][bc]++;
                end
                m_cnt[k]++;
                m_acc[k] += longint'(br_correct);
                if (m_cnt[k] == WIN) begin
                    m_wcor[k] = m_acc[k];
                    m_acc[k]  = 0;
                    m_cnt[k]  = 0;
                    m_widx[k] = (m_widx[k] + 1) & mx;
                    if (m_pend[k] && !win_ack) m_ovr[k] = 1;
                    m_pend[k] = 1;
                end else if (win_ack) begin
                    m_pend[k] = 0;
                end
            end else if (win_ack) begin
                m_pend[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("A.total", a_tot, m_tot[0]);
        chk("A.correct", a_cor, m_cor[0]);
        chk("A.win_valid", a_wv, m_pend[0]);
        chk("A.win_correct", a_wcor, m_wcor[0]);
        chk("A.win_index", a_widx, m_widx[0]);
        chk("A.win_overrun", a_ovr, m_ovr[0]);
        chk("A.rd_total", a_rdt, m_rdt[0]);
        chk("A.rd_correct", a_rdc, m_rdc[0]);
        chk("B.total", b_tot, m_tot[1]);
        chk("B.correct", b_cor, m_cor[1]);
        chk("B.win_valid", b_wv, m_pend[1]);
        chk("B.win_correct", b_wcor, m_wcor[1]);
        chk("B.win_index", b_widx, m_widx[1]);
        chk("B.win_overrun", b_ovr, m_ovr[1]);
        chk("B.rd_total", b_rdt, m_rdt[1]);
        chk("B.rd_correct", b_rdc, m_rdc[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic send(input logic v, input logic c, input logic [1:0] ch);
        br_valid   = v;
        br_correct = c;
        br_ch      = ch;
        tick();
    endtask

    initial begin
        int pat1[4] = '{1, 0, 1, 1};
        int pat3[4] = '{1, 1, 0, 1};

        reset = 1'b1;
        br_valid = 0; br_correct = 0; br_ch = 0;
        clear = 0; freeze = 0; win_ack = 0; rd_ch = 0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Test 1: first window
        for (int i = 0; i < 4; i++) send(1'b1, 1'(pat1[i]), 2'd0);
        chk("T1.win_valid", a_wv, 1);
        chk("T1.win_correct", a_wcor, 3);
        chk("T1.win_index", a_widx, 1);
        chk("T1.total", a_tot, 4);
        chk("T1.correct", a_cor, 3);

        // Test 2: overrun without ack
        for (int i = 0; i < 8; i++) send(1'b1, 1'b1, 2'd1);
        chk("T2.overrun", a_ovr, 1);
        chk("T2.win_correct", a_wcor, 4);
        chk("T2.win_index", a_widx, 3);
        win_ack = 1'b1;
        send(1'b0, 1'b0, 2'd0);
        win_ack = 1'b0;
        chk("T2.ack_valid", a_wv, 0);
        chk("T2.ack_overrun", a_ovr, 1);

        // Test 3: close and ack in the same cycle
        clear = 1'b1;
        send(1'b0, 1'b0, 2'd0);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 2'd3);
        for (int i = 0; i < 3; i++) send(1'b1, 1'(pat3[i]), 2'd0);
        win_ack = 1'b1;
        send(1'b1, 1'(pat3[3]), 2'd0);
        win_ack = 1'b0;
        chk("T3.win_valid", a_wv, 1);
        chk("T3.win_correct", a_wcor, 3);
        chk("T3.win_index", a_widx, 2);
        chk("T3.overrun", a_ovr, 0);

        // Test 4: saturation and dropped channel on the narrow instance
        clear = 1'b1;
        send(1'b0, 1'b0, 2'd0);
        clear = 1'b0;
        for (int i = 0; i < 20; i++) send(1'b1, 1'b1, 2'd2);
        chk("T4.sat_total", b_tot, 15);
        chk("T4.sat_correct", b_cor, 15);
        rd_ch = 2'd2;
        send(1'b0, 1'b0, 2'd0);
        chk("T4.rd_total", b_rdt, 15);
        chk("T4.rd_correct", b_rdc, 15);
        clear = 1'b1;
        send(1'b0, 1'b0, 2'd0);
        clear = 1'b0;
        send(1'b1, 1'b1, 2'd3);
        chk("T4.drop_total", b_tot, 1);
        for (int c = 0; c < 3; c++) begin
            rd_ch = 2'(c);
            send(1'b0, 1'b0, 2'd0);
            chk("T4.drop_rd", b_rdt, 0);
        end

        // Test 5: freeze and clear
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) send(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        freeze = 1'b0;
        chk("T5.frozen_total", a_tot, 1);
        clear = 1'b1;
        send(1'b1, 1'b1, 2'd0);
        clear = 1'b0;
        chk("T5.clr_total", a_tot, 0);
        chk("T5.clr_valid", a_wv, 0);
        chk("T5.clr_overrun", a_ovr, 0);

        // Test 6: asynchronous reset between edges
        send(1'b1, 1'b1, 2'd1);
        send(1'b1, 1'b1, 2'd1);
        br_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("T6.async_total", a_tot, 0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 2'd0);
        chk("T6.not_yet", a_wv, 0);
        send(1'b1, 1'b0, 2'd0);
        chk("T6.closed", a_wv, 1);
        chk("T6.win_correct", a_wcor, 3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            freeze  = ($urandom_range(0, 7) == 0);
            clear   = ($urandom_range(0, 49) == 0);
            win_ack = ($urandom_range(0, 3) == 0);
            rd_ch   = 2'($urandom_range(0, 2));
            send($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
